// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_e;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/if_out_slot.sv
// if_out_slot: single-entry valid/ready output register with load, drain and clear.
module if_out_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic         ready,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            valid <= clear ? 1'b0 : load ? 1'b1 : valid && !ready;
            if (load) q <= d;
        end
endmodule

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: owns the PC and issues single-outstanding imem fetches into an IF/ID slot.
// FETCH_ALIGN_CHECK_EN adds if_misalign_o and fills the slot with a NOP on misaligned PCs.
module pc_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_DROP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc_i,
    input  logic        flush_i,
    output logic [31:0] pc_plus4_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        if_misalign_o,
`endif
    input  logic        if_ready_i
);
    localparam int DW = $clog2(MAX_DROP + 1);
`ifdef FETCH_ALIGN_CHECK_EN
    localparam int SW = 65;
`else
    localparam int SW = 64;
`endif
    fetch_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [DW-1:0] drop_q, drop_d;
    logic misal, load, drop_last;
    logic [SW-1:0] slot_d, slot_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign misal       = pc_q[1:0] != 2'b00;
    assign imem_addr_o = pc_q;
    assign slot_d      = {misal, pc_q, misal ? NOP_INSTR : imem_rdata_i};
    assign {if_misalign_o, if_pc_o, if_instr_o} = slot_q;
`else
    assign misal       = 1'b0;
    // Low PC bits never reach memory: a misaligned PC fetches its enclosing word.
    assign imem_addr_o = {pc_q[31:2], 2'b00};
    assign slot_d      = {pc_q, imem_rdata_i};
    assign {if_pc_o, if_instr_o} = slot_q;
`endif
    assign pc_plus4_o = pc_q + PC_STEP;
    assign imem_req_o = state_q == REQ && !misal;
    assign drop_last  = drop_q == DW'(MAX_DROP - 1);
    assign pc_d       = (flush_i || (state_q == WAIT && imem_rvalid_i)) ? next_pc_i : pc_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        load    = 1'b0;
        case (state_q)
            IDLE: state_d = (flush_i || ((!if_valid_o || if_ready_i) && !misal)) ? REQ : IDLE;
            REQ: begin
                if (flush_i) state_d = (imem_req_o && imem_gnt_i) ? DROP : REQ;
                else if (misal) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end else if (imem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                load    = imem_rvalid_i && !flush_i;
                state_d = imem_rvalid_i ? (flush_i ? REQ : IDLE) : (flush_i ? DROP : WAIT);
            end
            DROP: if (imem_rvalid_i) begin
                drop_d  = drop_last ? '0 : drop_q + 1'b1;
                state_d = !drop_last ? DROP : flush_i ? REQ : IDLE;
            end
        endcase
    end
    if_out_slot #(.W(SW)) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .clear (flush_i),
        .ready (if_ready_i),
        .d     (slot_d),
        .valid (if_valid_o),
        .q     (slot_q)
    );
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed fetch scenarios followed by a randomized memory/pipeline environment.
module tb_pc_fetch_stage;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
    logic [31:0] rdata = '0, target = '0, next_pc;
    logic [31:0] pc4, addr, ifpc, instr;
    logic req, v;
`ifdef FETCH_ALIGN_CHECK_EN
    logic mis;
`endif
    int tests = 0, failed = 0;
    logic [31:0] exp_pc, paddr;
    bit pend, fl_prev;
    int cnt, acc;

    always #5 clk = ~clk;
    // The next-PC mux: branch target when redirecting, sequential otherwise.
    assign next_pc = flush ? target : pc4;

    pc_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .next_pc_i     (next_pc),
        .flush_i       (flush),
        .pc_plus4_o    (pc4),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .if_valid_o    (v),
        .if_pc_o       (ifpc),
        .if_instr_o    (instr),
`ifdef FETCH_ALIGN_CHECK_EN
        .if_misalign_o (mis),
`endif
        .if_ready_i    (ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    initial begin
        #1;
        chk("rst_req", {31'b0, req}, 0);
        chk("rst_addr", addr, 0);
        chk("rst_pc4", pc4, 4);
        chk("rst_valid", {31'b0, v}, 0);
        chk("rst_ifpc", ifpc, 0);
        chk("rst_instr", instr, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_mis", {31'b0, mis}, 0);
`endif
        tick; tick;
        rst_n = 1'b1;
        chk("idle_req", {31'b0, req}, 0);
        tick;
        chk("first_req", {31'b0, req}, 1);
        chk("first_addr", addr, 0);
        gnt = 1'b1; ready = 1'b1; tick; gnt = 1'b0;
        chk("wait_req", {31'b0, req}, 0);
        rvalid = 1'b1; rdata = 32'hAAAA_0001; tick; rvalid = 1'b0;
        chk("t1_valid", {31'b0, v}, 1);
        chk("t1_pc", ifpc, 0);
        chk("t1_instr", instr, 32'hAAAA_0001);
        chk("t1_next_addr", addr, 4);
        tick;
        chk("t1_drained", {31'b0, v}, 0);
        chk("t1_req", {31'b0, req}, 1);
        chk("t1_req_addr", addr, 4);
        gnt = 1'b1; tick; gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'hBBBB_0002; ready = 1'b0; tick; rvalid = 1'b0;
        chk("t2_pc", ifpc, 4);
        chk("t2_instr", instr, 32'hBBBB_0002);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_req", {31'b0, req}, 0);
            chk("t2_hold_valid", {31'b0, v}, 1);
            tick;
        end
        ready = 1'b1; tick;
        chk("t2_req", {31'b0, req}, 1);
        chk("t2_addr", addr, 8);
        chk("t2_valid", {31'b0, v}, 0);
        gnt = 1'b1; tick; gnt = 1'b0;
        flush = 1'b1; target = 32'h100; tick; flush = 1'b0;
        chk("t3_valid", {31'b0, v}, 0);
        chk("t3_req", {31'b0, req}, 0);
        chk("t3_addr", addr, 32'h100);
        tick;
        rvalid = 1'b1; rdata = 32'hDEAD_0000; tick; rvalid = 1'b0;
        chk("t3_dropped", {31'b0, v}, 0);
        chk("t3_idle", {31'b0, req}, 0);
        tick;
        chk("t3_req", {31'b0, req}, 1);
        chk("t3_req_addr", addr, 32'h100);
        gnt = 1'b1; tick; gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0; flush = 1'b1; target = 32'h200; tick;
        rvalid = 1'b0; flush = 1'b0;
        chk("t4_valid", {31'b0, v}, 0);
        chk("t4_req", {31'b0, req}, 1);
        chk("t4_addr", addr, 32'h200);
        flush = 1'b1; target = 32'hFFFF_FFFC; tick; flush = 1'b0;
        chk("t5_req", {31'b0, req}, 1);
        chk("t5_addr", addr, 32'hFFFF_FFFC);
        chk("t5_pc4_wrap", pc4, 0);
        gnt = 1'b1; tick; gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'hCCCC_0003; ready = 1'b0; tick; rvalid = 1'b0;
        chk("t5_valid", {31'b0, v}, 1);
        chk("t5_pc", ifpc, 32'hFFFF_FFFC);
        chk("t5_instr", instr, 32'hCCCC_0003);
        chk("t5_next_addr", addr, 0);
        chk("t5_next_pc4", pc4, 4);
        ready = 1'b1; tick;
        chk("t5_req_wrap", {31'b0, req}, 1);
        chk("t5_req_addr", addr, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        flush = 1'b1; target = 32'h102; ready = 1'b0; tick; flush = 1'b0;
        chk("al_noreq", {31'b0, req}, 0);
        tick;
        chk("al_valid", {31'b0, v}, 1);
        chk("al_pc", ifpc, 32'h102);
        chk("al_instr", instr, 32'h0000_0013);
        chk("al_mis", {31'b0, mis}, 1);
        ready = 1'b1; tick;
        chk("al_drained", {31'b0, v}, 0);
        tick;
        chk("al_parked", {31'b0, req}, 0);
        flush = 1'b1; target = 32'h0; tick; flush = 1'b0;
        chk("al_refetch", {31'b0, req}, 1);
        chk("al_refetch_addr", addr, 0);
`endif
        gnt = 1'b1; tick; gnt = 1'b0;
        rst_n = 1'b0; #1;
        chk("mid_rst_req", {31'b0, req}, 0);
        chk("mid_rst_addr", addr, 0);
        tick;
        rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h5555_5555; tick; rvalid = 1'b0;
        chk("stray_valid", {31'b0, v}, 0);
        chk("stray_req", {31'b0, req}, 1);
        exp_pc = 32'h0; pend = 1'b0; fl_prev = 1'b0; acc = 0; cnt = 0; paddr = '0;
        for (int k = 0; k < 800; k++) begin
            rvalid = 1'b0;
            rdata  = $urandom;
            if (pend) begin
                if (cnt == 0) begin
                    rvalid = 1'b1;
                    rdata  = mem(paddr);
                    pend   = 1'b0;
                end else cnt--;
            end
            gnt    = 1'($urandom_range(0, 1));
            flush  = $urandom_range(0, 11) == 0;
            target = 32'($urandom_range(0, 255)) << 2;
            ready  = !flush && $urandom_range(0, 3) != 0;
            #1;
            chk("rnd_pc4", pc4, addr + 32'd4);
            if (req && gnt) begin
                if (!flush) chk("rnd_req_addr", addr, exp_pc);
                pend  = 1'b1;
                cnt   = $urandom_range(0, 2);
                paddr = addr;
            end
            if (v && ready) begin
                chk("rnd_pc", ifpc, exp_pc);
                chk("rnd_instr", instr, mem(exp_pc));
                exp_pc += 32'd4;
                acc++;
            end
            if (flush) exp_pc = target;
            fl_prev = flush;
            @(posedge clk); #1;
            if (fl_prev) chk("rnd_flush_clear", {31'b0, v}, 0);
        end
        flush = 1'b0; rvalid = 1'b0; gnt = 1'b0;
        chk("rnd_progress", 32'(acc >= 30), 1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
